// File: rtl/ibex_fetch_align_buffer.sv
// Halfword-granular fetch buffer: accepts aligned 32-bit fetch words and presents one
// 16- or 32-bit instruction per handshake together with its PC and error flag.
module ibex_fetch_align_buffer #(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [31:0] clear_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o
);

  localparam int unsigned SLOTS = 2 * DEPTH;
  localparam int unsigned PW    = $clog2(SLOTS);
  localparam int unsigned CW    = $clog2(SLOTS + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam logic [PW:0] SLOTS_W   = (PW+1)'(SLOTS);
  localparam cnt_t        READY_MAX = cnt_t'(SLOTS - 2);
  localparam cnt_t        CNT_TWO   = cnt_t'(2);

  logic [15:0]      hw_q [SLOTS];
  logic [SLOTS-1:0] err_q;
  ptr_t             rd_ptr_q, wr_ptr_q;
  cnt_t             count_q;
  logic [31:0]      pc_q;
  logic             skip_lo_q;

  ptr_t        rd_ptr_nxt1, wr_ptr_nxt1;
  logic [15:0] hw0, hw1;
  logic        err0, err1;
  logic        has1, has2, is_compressed;
  logic        push_en, pop_en;
  logic [1:0]  push_num, pop_num;
  cnt_t        push_cnt, pop_cnt;

  // Pointer arithmetic modulo SLOTS, which need not be a power of two.
  function automatic ptr_t ptr_add(input ptr_t p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + {{(PW-1){1'b0}}, n};
    if (s >= SLOTS_W) s = s - SLOTS_W;
    return s[PW-1:0];
  endfunction

  assign rd_ptr_nxt1   = ptr_add(rd_ptr_q, 2'd1);
  assign wr_ptr_nxt1   = ptr_add(wr_ptr_q, 2'd1);
  assign hw0           = hw_q[rd_ptr_q];
  assign hw1           = hw_q[rd_ptr_nxt1];
  assign err0          = err_q[rd_ptr_q];
  assign err1          = err_q[rd_ptr_nxt1];
  assign has1          = (count_q != '0);
  assign has2          = (count_q >= CNT_TWO);
  assign is_compressed = (hw0[1:0] != 2'b11);

  assign in_ready_o = (count_q <= READY_MAX);
  assign out_addr_o = pc_q;

  always_comb begin
    out_valid_o = 1'b0;
    out_rdata_o = 32'h0;
    out_err_o   = 1'b0;
    if (has1) begin
      out_rdata_o = {(has2 ? hw1 : 16'h0), hw0};
      if (is_compressed) begin
        out_valid_o = 1'b1;
        out_err_o   = err0;
      end else begin
        // A lone errored upper-less halfword is still handed on so the error surfaces.
        out_valid_o = has2 | err0;
        out_err_o   = err0 | (has2 & err1);
      end
    end
  end

  always_comb begin
    push_en  = in_valid_i && in_ready_o && !clear_i;
    pop_en   = out_valid_o && out_ready_i && !clear_i;
    push_num = skip_lo_q ? 2'd1 : 2'd2;
    pop_num  = (is_compressed || !has2) ? 2'd1 : 2'd2;
    push_cnt = push_en ? cnt_t'(push_num) : '0;
    pop_cnt  = pop_en  ? cnt_t'(pop_num)  : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pc_q      <= 32'h0;
      skip_lo_q <= 1'b0;
    end else if (clear_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pc_q      <= clear_addr_i & ~32'h1;
      skip_lo_q <= clear_addr_i[1];
    end else begin
      count_q <= count_q + push_cnt - pop_cnt;
      if (push_en) begin
        wr_ptr_q  <= ptr_add(wr_ptr_q, push_num);
        skip_lo_q <= 1'b0;
      end
      if (pop_en) begin
        rd_ptr_q <= ptr_add(rd_ptr_q, pop_num);
        pc_q     <= pc_q + ((pop_num == 2'd2) ? 32'd4 : 32'd2);
      end
    end
  end

  // Slot storage needs no reset: validity is tracked entirely by count_q.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      if (skip_lo_q) begin
        hw_q[wr_ptr_q]  <= in_rdata_i[31:16];
        err_q[wr_ptr_q] <= in_err_i;
      end else begin
        hw_q[wr_ptr_q]     <= in_rdata_i[15:0];
        err_q[wr_ptr_q]    <= in_err_i;
        hw_q[wr_ptr_nxt1]  <= in_rdata_i[31:16];
        err_q[wr_ptr_nxt1] <= in_err_i;
      end
    end
  end

endmodule

// File: tb/tb_ibex_fetch_align_buffer.sv
// Self-checking bench for ibex_fetch_align_buffer: directed vector table, fill/drain
// sequences and a randomized run against a halfword-queue reference model.
module tb_ibex_fetch_align_buffer;

  localparam int DEPTH = 3;
  localparam int SLOTS = 2 * DEPTH;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_err, out_ready;
  logic [31:0] clear_addr, in_rdata;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_rdata, out_addr;

  int nvec  = 0;
  int nfail = 0;

  ibex_fetch_align_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .clear_addr_i(clear_addr),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_rdata_i  (in_rdata),
    .in_err_i    (in_err),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_rdata_o (out_rdata),
    .out_addr_o  (out_addr),
    .out_err_o   (out_err)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of {err, halfword} entries plus PC and skip flag.
  logic [16:0] mq[$];
  logic [31:0] mpc;
  logic        mskip;

  function automatic void modelOutputs(output logic v, output logic [31:0] rd, output logic e);
    v = 1'b0; rd = 32'h0; e = 1'b0;
    if (mq.size() >= 1) begin
      rd[15:0] = mq[0][15:0];
      if (mq.size() >= 2) rd[31:16] = mq[1][15:0];
      if (mq[0][1:0] != 2'b11) begin
        v = 1'b1;
        e = mq[0][16];
      end else begin
        v = (mq.size() >= 2) || mq[0][16];
        e = mq[0][16] | ((mq.size() >= 2) && mq[1][16]);
      end
    end
  endfunction

  function automatic void modelEdge(input logic r, input logic c, input logic [31:0] ca,
                                    input logic iv, input logic [31:0] id, input logic ie,
                                    input logic ordy);
    logic v, e, can_push;
    logic [31:0] rd;
    if (!r) begin
      mq.delete(); mpc = 32'h0; mskip = 1'b0;
    end else if (c) begin
      mq.delete(); mpc = {ca[31:1], 1'b0}; mskip = ca[1];
    end else begin
      modelOutputs(v, rd, e);
      can_push = (mq.size() <= SLOTS - 2);
      if (v && ordy) begin
        if (mq[0][1:0] != 2'b11 || mq.size() == 1) begin
          void'(mq.pop_front()); mpc = mpc + 32'd2;
        end else begin
          void'(mq.pop_front()); void'(mq.pop_front()); mpc = mpc + 32'd4;
        end
      end
      if (iv && can_push) begin
        if (!mskip) mq.push_back({ie, id[15:0]});
        mq.push_back({ie, id[31:16]});
        mskip = 1'b0;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model with the edge, sample #1 after.
  task automatic applyStimulus(input logic r, input logic c, input logic [31:0] ca,
                               input logic iv, input logic [31:0] id, input logic ie,
                               input logic ordy);
    rst_n = r; clear = c; clear_addr = ca;
    in_valid = iv; in_rdata = id; in_err = ie; out_ready = ordy;
    @(posedge clk);
    modelEdge(r, c, ca, iv, id, ie, ordy);
    #1;
  endtask

  task automatic checkModel(input string tag);
    logic v, e;
    logic [31:0] rd;
    modelOutputs(v, rd, e);
    checkOutput({tag, " in_ready"}, {31'h0, in_ready}, {31'h0, (mq.size() <= SLOTS - 2)});
    checkOutput({tag, " out_valid"}, {31'h0, out_valid}, {31'h0, v});
    checkOutput({tag, " out_addr"}, out_addr, mpc);
    if (v) begin
      checkOutput({tag, " out_rdata"}, out_rdata, rd);
      checkOutput({tag, " out_err"}, {31'h0, out_err}, {31'h0, e});
    end
  endtask

  typedef struct {
    logic        clr;
    logic [31:0] caddr;
    logic        iv;
    logic [31:0] idata;
    logic        ierr;
    logic        ordy;
    logic        ev;
    logic [31:0] erd;
    logic [31:0] eaddr;
    logic        ee;
    logic        eir;
  } vec_t;

  vec_t tbl[24];
  logic [31:0] words[5];

  initial begin
    // Directed scenarios; each row's expectations hold just after that row's edge.
    tbl[0]  = '{1'b1, 32'h100,      1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h100,      1'b0, 1'b1};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 32'h00A20513, 1'b0, 1'b0, 1'b1, 32'h00A20513, 32'h100,      1'b0, 1'b1};
    tbl[2]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        32'h104,      1'b0, 1'b1};
    tbl[3]  = '{1'b1, 32'h103,      1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h102,      1'b0, 1'b1};
    tbl[4]  = '{1'b0, 32'h0,        1'b1, 32'h45010001, 1'b0, 1'b0, 1'b1, 32'h00004501, 32'h102,      1'b0, 1'b1};
    tbl[5]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        32'h104,      1'b0, 1'b1};
    tbl[6]  = '{1'b1, 32'h200,      1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h200,      1'b0, 1'b1};
    tbl[7]  = '{1'b0, 32'h0,        1'b1, 32'h05134505, 1'b0, 1'b0, 1'b1, 32'h05134505, 32'h200,      1'b0, 1'b1};
    tbl[8]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h00000513, 32'h202,      1'b0, 1'b1};
    tbl[9]  = '{1'b0, 32'h0,        1'b1, 32'h000000A2, 1'b0, 1'b0, 1'b1, 32'h00A20513, 32'h202,      1'b0, 1'b1};
    tbl[10] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h00000000, 32'h206,      1'b0, 1'b1};
    tbl[11] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        32'h208,      1'b0, 1'b1};
    tbl[12] = '{1'b1, 32'h300,      1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h300,      1'b0, 1'b1};
    tbl[13] = '{1'b0, 32'h0,        1'b1, 32'h05130001, 1'b0, 1'b0, 1'b1, 32'h05130001, 32'h300,      1'b0, 1'b1};
    tbl[14] = '{1'b0, 32'h0,        1'b1, 32'h000000A2, 1'b1, 1'b1, 1'b1, 32'h00A20513, 32'h302,      1'b1, 1'b1};
    tbl[15] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h00000000, 32'h306,      1'b1, 1'b1};
    tbl[16] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        32'h308,      1'b0, 1'b1};
    tbl[17] = '{1'b1, 32'h402,      1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h402,      1'b0, 1'b1};
    tbl[18] = '{1'b0, 32'h0,        1'b1, 32'h0513FFFF, 1'b1, 1'b0, 1'b1, 32'h00000513, 32'h402,      1'b1, 1'b1};
    tbl[19] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        32'h404,      1'b0, 1'b1};
    tbl[20] = '{1'b0, 32'h0,        1'b1, 32'h00A20513, 1'b0, 1'b0, 1'b1, 32'h00A20513, 32'h404,      1'b0, 1'b1};
    tbl[21] = '{1'b1, 32'hFFFFFFFE, 1'b1, 32'h11111111, 1'b0, 1'b1, 1'b0, 32'h0,        32'hFFFFFFFE, 1'b0, 1'b1};
    tbl[22] = '{1'b0, 32'h0,        1'b1, 32'h00014501, 1'b0, 1'b0, 1'b1, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b1};
    tbl[23] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        32'h00000000, 1'b0, 1'b1};

    #2;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("reset out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset in_ready",  {31'h0, in_ready},  32'h1);
    checkOutput("reset out_rdata", out_rdata, 32'h0);
    checkOutput("reset out_addr",  out_addr,  32'h0);
    checkOutput("reset out_err",   {31'h0, out_err},   32'h0);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, tbl[i].clr, tbl[i].caddr, tbl[i].iv, tbl[i].idata, tbl[i].ierr, tbl[i].ordy);
      checkOutput($sformatf("vec%0d out_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].ev});
      checkOutput($sformatf("vec%0d out_rdata", i), out_rdata, tbl[i].erd);
      checkOutput($sformatf("vec%0d out_addr", i),  out_addr,  tbl[i].eaddr);
      checkOutput($sformatf("vec%0d out_err", i),   {31'h0, out_err}, {31'h0, tbl[i].ee});
      checkOutput($sformatf("vec%0d in_ready", i),  {31'h0, in_ready}, {31'h0, tbl[i].eir});
    end

    // Fill with 32-bit instructions while the consumer stalls; only DEPTH words fit.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) words[i] = {16'hA000 + 16'(i), 16'h0013 + 16'(i << 8)};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, words[i], 1'b0, 1'b0);
      checkModel("fill");
    end
    checkOutput("full in_ready", {31'h0, in_ready}, 32'h0);
    for (int k = 0; k < DEPTH; k++) begin
      checkOutput($sformatf("drain%0d out_rdata", k), out_rdata, words[k]);
      checkOutput($sformatf("drain%0d out_addr", k), out_addr, 32'(4 * k));
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    end
    checkOutput("drained out_valid", {31'h0, out_valid}, 32'h0);

    // Two words resident, then push and pop together: occupancy stays at four slots.
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, words[i], 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, words[(i + 2) % 5], 1'b0, 1'b1);
      checkOutput("steady in_ready", {31'h0, in_ready}, 32'h1);
      checkOutput("steady out_valid", {31'h0, out_valid}, 32'h1);
      checkModel("steady");
    end

    // Randomized traffic, including clears and occasional mid-run resets.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic r, c, iv, ie, ordy;
      logic [31:0] ca, id;
      r    = ($urandom_range(0, 199) != 0);
      c    = ($urandom_range(0, 39) == 0);
      ca   = (i % 97 == 5) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
      iv   = ($urandom_range(0, 9) < 7);
      id   = $urandom;
      ie   = ($urandom_range(0, 9) == 0);
      ordy = ($urandom_range(0, 9) < 6);
      applyStimulus(r, c, ca, iv, id, ie, ordy);
      checkModel("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
